me_search: RTL

Parametrised full-search motion-estimation engine for the inter-prediction path. Consumes one current-block row and one reference-candidate row per accepted beat. Computes the SAD of every candidate position in a square search range and tracks the minimum SAD with its motion vector. Adds what the fixed-size SAD datapath lacks: candidate scan control, best-match selection, a valid/ready row handshake and threshold-based early termination.

---
 rtl/me_pkg.sv | 35 +++
 rtl/me_search_sad_row.sv | 92 +++++++++
 rtl/me_search.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/me_pkg.sv
// Shared definitions for the me_search motion-estimation engine.
// Contents:
//   state_t        engine control states (IDLE, RUN, FLUSH, DONE)
//   sad_w()        width of a block SAD for a given block edge and pixel width
//   mv_w()         width of a signed motion-vector component for a search range
//   pixel_t/sad_t/mv_t  typedefs at the default engine configuration
package me_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    // A block SAD is MACRO_DIM*MACRO_DIM differences of PIXEL_W bits each,
    // so it needs 2*clog2(MACRO_DIM) extra bits and can never overflow.
    function automatic int sad_w(input int macro_dim, input int pixel_w);
        return pixel_w + 2 * $clog2(macro_dim);
    endfunction

    // Signed range must hold -SEARCH_RANGE..+SEARCH_RANGE.
    function automatic int mv_w(input int search_range);
        return $clog2(search_range + 1) + 1;
    endfunction

    localparam int DEF_MACRO_DIM    = 16;
    localparam int DEF_SEARCH_RANGE = 16;
    localparam int DEF_PIXEL_W      = 8;

    typedef logic [DEF_PIXEL_W-1:0]                            pixel_t;
    typedef logic [sad_w(DEF_MACRO_DIM, DEF_PIXEL_W)-1:0]      sad_t;
    typedef logic signed [mv_w(DEF_SEARCH_RANGE)-1:0]          mv_t;

endpackage

// File: rtl/me_search_sad_row.sv
// sad_row: two-stage row SAD datapath.
//   Stage 1 registers the per-pixel absolute differences |cur - ref|.
//   Stage 2 registers the sum of those differences (the row SAD).
// A valid bit and a last-row-of-candidate flag travel with the data.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   i_flush      drop everything in flight (same effect as reset on control)
//   i_valid      i_cur/i_ref carry a row to be processed
//   i_last       that row is the last row of its candidate
//   i_cur, i_ref packed rows, pixel 0 in the LSBs
//   o_valid      o_sum holds a row SAD this cycle
//   o_last       o_sum belongs to the last row of a candidate
//   o_sum        row SAD
//   o_pending    some row is still inside the two stages
module sad_row
    import me_pkg::*;
#(
    parameter  int MACRO_DIM = 16,
    parameter  int PIXEL_W   = 8,
    localparam int ROW_W     = MACRO_DIM * PIXEL_W,
    localparam int SUM_W     = PIXEL_W + $clog2(MACRO_DIM)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_valid,
    input  logic             i_last,
    input  logic [ROW_W-1:0] i_cur,
    input  logic [ROW_W-1:0] i_ref,
    output logic             o_valid,
    output logic             o_last,
    output logic [SUM_W-1:0] o_sum,
    output logic             o_pending
);

    logic [PIXEL_W-1:0] w_diff [MACRO_DIM];
    logic [PIXEL_W-1:0] r_diff [MACRO_DIM];
    logic [SUM_W-1:0]   w_sum;
    logic [SUM_W-1:0]   r_sum;
    logic               r_s1_valid;
    logic               r_s1_last;
    logic               r_s2_valid;
    logic               r_s2_last;

    always_comb begin
        for (int k = 0; k < MACRO_DIM; k++) begin
            if (i_cur[k*PIXEL_W +: PIXEL_W] > i_ref[k*PIXEL_W +: PIXEL_W]) begin
                w_diff[k] = i_cur[k*PIXEL_W +: PIXEL_W] - i_ref[k*PIXEL_W +: PIXEL_W];
            end else begin
                w_diff[k] = i_ref[k*PIXEL_W +: PIXEL_W] - i_cur[k*PIXEL_W +: PIXEL_W];
            end
        end
    end

    always_comb begin
        w_sum = '0;
        for (int k = 0; k < MACRO_DIM; k++) begin
            w_sum = w_sum + SUM_W'(r_diff[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s2_last  <= 1'b0;
        end else begin
            r_s1_valid <= i_valid;
            r_s1_last  <= i_valid && i_last;
            r_s2_valid <= r_s1_valid;
            r_s2_last  <= r_s1_last;
        end
    end

    // Data registers only load when a row is present; no reset needed
    // because the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (i_valid) begin
            r_diff <= w_diff;
        end
        if (r_s1_valid) begin
            r_sum <= w_sum;
        end
    end

    assign o_valid   = r_s2_valid;
    assign o_last    = r_s2_last;
    assign o_sum     = r_sum;
    assign o_pending = r_s1_valid || r_s2_valid;

endmodule

// File: rtl/me_search.sv
// me_search: full-search motion-estimation engine.
// Scans every candidate offset in [-SEARCH_RANGE, +SEARCH_RANGE]^2 in raster
// order (mvy outer, mvx inner), one current/reference row pair per accepted
// beat, and reports the minimum block SAD with its motion vector.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               begin a search (only honoured in IDLE)
//   sad_thresh          early-exit threshold captured with start, 0 = off
//   row_valid/row_ready row handshake
//   cur_row, ref_row    packed rows, pixel 0 in the LSBs
//   busy                search in progress (RUN or FLUSH)
//   done                one-cycle pulse, results valid from this cycle
//   best_sad            minimum SAD found
//   best_mvx, best_mvy  signed offset of the best candidate
//   early_exit          search ended because a SAD fell below sad_thresh
//
// Handshake: a row transfers on a rising edge where row_valid && row_ready.
// row_ready is high exactly in RUN and does not depend on row_valid; the
// producer may hold or drop row_valid freely and must keep the row stable
// until it transfers. Rows accepted after an early exit is detected are
// consumed but ignored.
module me_search
    import me_pkg::*;
#(
    parameter  int MACRO_DIM    = 16,
    parameter  int SEARCH_RANGE = 16,
    parameter  int PIXEL_W      = 8,
    localparam int SAD_W        = sad_w(MACRO_DIM, PIXEL_W),
    localparam int MV_W         = mv_w(SEARCH_RANGE),
    localparam int ROW_W        = MACRO_DIM * PIXEL_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [SAD_W-1:0]       sad_thresh,
    input  logic                   row_valid,
    output logic                   row_ready,
    input  logic [ROW_W-1:0]       cur_row,
    input  logic [ROW_W-1:0]       ref_row,
    output logic                   busy,
    output logic                   done,
    output logic [SAD_W-1:0]       best_sad,
    output logic signed [MV_W-1:0] best_mvx,
    output logic signed [MV_W-1:0] best_mvy,
    output logic                   early_exit
);

    localparam int NUM_CAND  = (2 * SEARCH_RANGE + 1) * (2 * SEARCH_RANGE + 1);
    localparam int ROW_CNT_W = $clog2(MACRO_DIM);
    localparam int CAND_W    = $clog2(NUM_CAND + 1);
    localparam int SUM_W     = PIXEL_W + $clog2(MACRO_DIM);

    localparam logic signed [MV_W-1:0] MV_MIN = MV_W'(-SEARCH_RANGE);
    localparam logic signed [MV_W-1:0] MV_MAX = MV_W'(SEARCH_RANGE);

    state_t r_state;
    state_t w_state_nxt;

    logic                   w_start_acc;
    logic                   w_accept;
    logic                   w_feed;
    logic                   w_last_row;
    logic                   w_last_cand;
    logic                   w_flush;
    logic                   w_pipe_empty;

    logic [ROW_CNT_W-1:0]   r_row_cnt;
    logic [CAND_W-1:0]      r_cand_cnt;

    logic                   w_s2_valid;
    logic                   w_s2_last;
    logic [SUM_W-1:0]       w_s2_sum;
    logic                   w_s_pending;

    logic [SAD_W-1:0]       r_acc;
    logic                   r_acc_start;
    logic                   r_cmp_valid;

    logic [SAD_W-1:0]       r_thresh;
    logic signed [MV_W-1:0] r_mvx;
    logic signed [MV_W-1:0] r_mvy;
    logic [SAD_W-1:0]       r_best_sad;
    logic signed [MV_W-1:0] r_best_mvx;
    logic signed [MV_W-1:0] r_best_mvy;
    logic                   r_early_exit;

    logic                   w_cmp_en;
    logic                   w_better;
    logic                   w_hit;

    assign w_start_acc  = (r_state == IDLE) && start;
    assign w_accept     = row_valid && row_ready;
    assign w_feed       = w_accept && !r_early_exit;
    assign w_last_row   = (r_row_cnt == ROW_CNT_W'(MACRO_DIM - 1));
    assign w_last_cand  = (r_cand_cnt == CAND_W'(NUM_CAND - 1));
    // Anything left in the datapath outside a search is stale.
    assign w_flush      = (r_state == IDLE) || (r_state == DONE);
    assign w_pipe_empty = !w_s_pending && !w_s2_valid && !r_cmp_valid;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                // r_early_exit is set by the compare, so ready falls one
                // cycle after it.
                if (r_early_exit || (w_accept && w_last_row && w_last_cand)) begin
                    w_state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                // After an early exit the remaining pipeline is discarded.
                if (r_early_exit || w_pipe_empty) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign row_ready = (r_state == RUN);
    assign busy      = (r_state == RUN) || (r_state == FLUSH);
    assign done      = (r_state == DONE);

    // ---------------- input-side row/candidate counters ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_row_cnt  <= '0;
            r_cand_cnt <= '0;
        end else if (w_start_acc) begin
            r_row_cnt  <= '0;
            r_cand_cnt <= '0;
        end else if (w_accept) begin
            r_row_cnt <= r_row_cnt + 1'b1;
            if (w_last_row) begin
                r_cand_cnt <= r_cand_cnt + 1'b1;
            end
        end
    end

    // ---------------- row SAD stages 1 and 2 ----------------
    sad_row #(
        .MACRO_DIM (MACRO_DIM),
        .PIXEL_W   (PIXEL_W)
    ) u_sad_row (
        .clk       (clk),
        .rst       (rst),
        .i_flush   (w_flush),
        .i_valid   (w_feed),
        .i_last    (w_last_row),
        .i_cur     (cur_row),
        .i_ref     (ref_row),
        .o_valid   (w_s2_valid),
        .o_last    (w_s2_last),
        .o_sum     (w_s2_sum),
        .o_pending (w_s_pending)
    );

    // ---------------- stage 3: block accumulator ----------------
    always_ff @(posedge clk) begin
        if (rst || w_flush) begin
            r_acc       <= '0;
            r_acc_start <= 1'b1;
            r_cmp_valid <= 1'b0;
        end else begin
            r_cmp_valid <= w_s2_valid && w_s2_last;
            if (w_s2_valid) begin
                // First row of a candidate restarts the sum.
                r_acc       <= (r_acc_start ? '0 : r_acc) + SAD_W'(w_s2_sum);
                r_acc_start <= w_s2_last;
            end
        end
    end

    // ---------------- compare / best-match update ----------------
    assign w_cmp_en = r_cmp_valid && !r_early_exit;
    assign w_better = (r_acc < r_best_sad);
    assign w_hit    = (r_thresh != '0) && (r_acc < r_thresh);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_thresh     <= '0;
            r_mvx        <= '0;
            r_mvy        <= '0;
            r_best_sad   <= '0;
            r_best_mvx   <= '0;
            r_best_mvy   <= '0;
            r_early_exit <= 1'b0;
        end else if (w_start_acc) begin
            r_thresh     <= sad_thresh;
            r_mvx        <= MV_MIN;
            r_mvy        <= MV_MIN;
            r_best_sad   <= '1;
            r_best_mvx   <= '0;
            r_best_mvy   <= '0;
            r_early_exit <= 1'b0;
        end else if (w_cmp_en) begin
            // Strict less-than keeps the earlier candidate on a tie.
            if (w_better || w_hit) begin
                r_best_sad <= r_acc;
                r_best_mvx <= r_mvx;
                r_best_mvy <= r_mvy;
            end
            if (w_hit) begin
                r_early_exit <= 1'b1;
            end
            if (r_mvx == MV_MAX) begin
                r_mvx <= MV_MIN;
                r_mvy <= r_mvy + 1'b1;
            end else begin
                r_mvx <= r_mvx + 1'b1;
            end
        end
    end

    assign best_sad   = r_best_sad;
    assign best_mvx   = r_best_mvx;
    assign best_mvy   = r_best_mvy;
    assign early_exit = r_early_exit;

endmodule
